// File: rtl/slt_prescale_counter.sv
// Multi-channel event counter with a programmable per-channel prescaler, tick pulses and sticky overflow.
// Define SLT_PRESCALE_SATURATE_EN to make counts saturate at all-ones instead of wrapping.
module slt_prescale_counter #(
  parameter int WIDTH       = 64,
  parameter int NUM_CH      = 2,
  parameter int SEL_W       = 1,
  parameter int PRE_W       = 5,
  parameter int PRE_DEFAULT = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    En,
  input  logic [SEL_W-1:0]        Slt,
  input  logic                    Clr,
  input  logic                    Div_we,
  input  logic [PRE_W-1:0]        Div_in,
  output logic [NUM_CH*WIDTH-1:0] Count,
  output logic [NUM_CH-1:0]       Tick,
  output logic [NUM_CH-1:0]       Ovf
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_IDX    = SEL_W'(gi);
      localparam logic [PRE_W-1:0] DIV_RESET = (gi == 0) ? PRE_W'(1) : PRE_W'(PRE_DEFAULT);

      logic [WIDTH-1:0] count_reg;
      logic [PRE_W-1:0] pre_reg;
      logic [PRE_W-1:0] div_reg;
      logic             tick_reg;
      logic             ovf_reg;
      logic             sel;
      logic [PRE_W-1:0] eff_div;
      logic             last_event;

      // An out-of-range Slt matches no channel, so every channel simply holds.
      assign sel        = (Slt == CH_IDX);
      assign eff_div    = (div_reg == '0) ? PRE_W'(1) : div_reg;
      assign last_event = (pre_reg == eff_div - PRE_W'(1));

      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          count_reg <= '0;
          pre_reg   <= '0;
          div_reg   <= DIV_RESET;
          tick_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          if (sel) begin
            if (Clr) begin
              count_reg <= '0;
              pre_reg   <= '0;
              ovf_reg   <= 1'b0;
            end else if (Div_we) begin
              div_reg <= Div_in;
              pre_reg <= '0;
            end else if (En) begin
              if (last_event) begin
                pre_reg <= '0;
                if (&count_reg) begin
`ifdef SLT_PRESCALE_SATURATE_EN
                  ovf_reg <= 1'b1;
`else
                  count_reg <= '0;
                  ovf_reg   <= 1'b1;
                  tick_reg  <= 1'b1;
`endif
                end else begin
                  count_reg <= count_reg + WIDTH'(1);
                  tick_reg  <= 1'b1;
                end
              end else begin
                pre_reg <= pre_reg + PRE_W'(1);
              end
            end
          end
        end
      end

      assign Count[gi*WIDTH +: WIDTH] = count_reg;
      assign Tick[gi]                 = tick_reg;
      assign Ovf[gi]                  = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_slt_prescale_counter.sv
// Self-checking bench for slt_prescale_counter: directed scenarios plus randomized traffic against
// an event-counting reference model.
module tb_slt_prescale_counter;
  localparam int WIDTH       = 4;
  localparam int NUM_CH      = 3;
  localparam int SEL_W       = 2;
  localparam int PRE_W       = 5;
  localparam int PRE_DEFAULT = 4;
  localparam int MAXC        = (1 << WIDTH) - 1;

  logic                    Clk = 1'b0;
  logic                    Reset_n = 1'b0;
  logic                    En = 1'b0;
  logic [SEL_W-1:0]        Slt = '0;
  logic                    Clr = 1'b0;
  logic                    Div_we = 1'b0;
  logic [PRE_W-1:0]        Div_in = '0;
  logic [NUM_CH*WIDTH-1:0] Count;
  logic [NUM_CH-1:0]       Tick;
  logic [NUM_CH-1:0]       Ovf;

  int tests_run = 0;
  int fails = 0;

  // Reference model: events seen since the last increment, the divisor, the count, the flags.
  int m_count[NUM_CH];
  int m_pre[NUM_CH];
  int m_div[NUM_CH];
  int m_ovf[NUM_CH];
  int m_tick[NUM_CH];

  slt_prescale_counter #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .PRE_W(PRE_W), .PRE_DEFAULT(PRE_DEFAULT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Slt(Slt), .Clr(Clr), .Div_we(Div_we),
    .Div_in(Div_in), .Count(Count), .Tick(Tick), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  function automatic logic [NUM_CH*WIDTH-1:0] exp_count();
    logic [NUM_CH*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(m_count[i]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_tick[i] != 0);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ovf();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_ovf[i] != 0);
    return v;
  endfunction

  function automatic int ch_count(input int ch);
    logic [NUM_CH*WIDTH-1:0] c;
    c = Count;
    return int'(c[ch*WIDTH +: WIDTH]);
  endfunction

  // Drive one cycle of inputs, advance the model by the same cycle, sample 1 time unit after the edge.
  task automatic do_cycle(input logic rst_n, input logic en, input int slt, input logic clr,
                          input logic dwe, input int din);
    int s;
    int d;
    Reset_n = rst_n; En = en; Slt = SEL_W'(slt); Clr = clr; Div_we = dwe; Div_in = PRE_W'(din);
    @(posedge Clk);
    for (int i = 0; i < NUM_CH; i++) m_tick[i] = 0;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_count[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
        m_div[i] = (i == 0) ? 1 : PRE_DEFAULT;
      end
    end else if (slt < NUM_CH) begin
      s = slt;
      if (clr) begin
        m_count[s] = 0; m_pre[s] = 0; m_ovf[s] = 0;
      end else if (dwe) begin
        m_div[s] = din % (1 << PRE_W); m_pre[s] = 0;
      end else if (en) begin
        d = (m_div[s] == 0) ? 1 : m_div[s];
        m_pre[s] = m_pre[s] + 1;
        if (m_pre[s] == d) begin
          m_pre[s] = 0;
          if (m_count[s] == MAXC) begin
            m_ovf[s] = 1;
`ifndef SLT_PRESCALE_SATURATE_EN
            m_count[s] = 0;
            m_tick[s] = 1;
`endif
          end else begin
            m_count[s] = m_count[s] + 1;
            m_tick[s] = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_cycle(1'b0, 1'b1, 1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
    tests_run++;
    if (Count !== '0 || Tick !== '0 || Ovf !== '0) begin
      fails++;
      $display("FAIL reset_state: count=%h tick=%b ovf=%b required count=0 tick=0 ovf=0", Count, Tick, Ovf);
    end
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick[1] !== ((i % 4) == 3)) begin
        fails++;
        $display("FAIL reset_tick1 ev%0d: tick1=%b required %b", i + 1, Tick[1], (i % 4) == 3);
      end
    end
    tests_run++;
    if (ch_count(1) != 2 || ch_count(0) != 0) begin
      fails++;
      $display("FAIL reset_count1: count1=%0d count0=%0d required 2 and 0", ch_count(1), ch_count(0));
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_channel0();
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick !== 3'b001) begin
        fails++;
        $display("FAIL ch0_tick ev%0d: tick=%b required 001", i + 1, Tick);
      end
    end
    tests_run++;
    if (ch_count(0) != 10 || ch_count(1) != 2) begin
      fails++;
      $display("FAIL ch0_count: count0=%0d count1=%0d required 10 and 2", ch_count(0), ch_count(1));
    end
    $display("[TB] test_channel0 done");
  endtask

  task automatic test_divisor();
    do_cycle(1'b1, 1'b0, 1, 1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 1, 1'b0, 1'b1, 3);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
    tests_run++;
    if (ch_count(1) != 2) begin
      fails++;
      $display("FAIL div3_count: count1=%0d required 2", ch_count(1));
    end
    // pre should be 1: two more events complete the third group of three
    do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
    tests_run++;
    if (Tick[1] !== 1'b0) begin
      fails++;
      $display("FAIL div3_pre: tick1=%b required 0", Tick[1]);
    end
    do_cycle(1'b1, 1'b0, 1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick[1] !== 1'b1) begin
        fails++;
        $display("FAIL div0_tick ev%0d: tick1=%b required 1", i + 1, Tick[1]);
      end
    end
    tests_run++;
    if (ch_count(1) != 4) begin
      fails++;
      $display("FAIL div0_count: count1=%0d required 4", ch_count(1));
    end
    $display("[TB] test_divisor done");
  endtask

  task automatic test_priority();
    do_cycle(1'b1, 1'b0, 1, 1'b0, 1'b1, 4);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b1, 1, 1'b1, 1'b1, 9);
    tests_run++;
    if (ch_count(1) != 0 || Ovf[1] !== 1'b0 || Tick[1] !== 1'b0) begin
      fails++;
      $display("FAIL prio_clr: count1=%0d ovf1=%b tick1=%b required 0 0 0", ch_count(1), Ovf[1], Tick[1]);
    end
    // divisor must still be 4 and pre 0: tick exactly on the 4th event
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick[1] !== (i == 3)) begin
        fails++;
        $display("FAIL prio_div_kept ev%0d: tick1=%b required %b", i + 1, Tick[1], i == 3);
      end
    end
    do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b1, 2);
    tests_run++;
    if (ch_count(1) != 1 || Tick[1] !== 1'b0) begin
      fails++;
      $display("FAIL prio_dwe_en: count1=%0d tick1=%b required 1 0", ch_count(1), Tick[1]);
    end
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick[1] !== (i == 1)) begin
        fails++;
        $display("FAIL prio_div2 ev%0d: tick1=%b required %b", i + 1, Tick[1], i == 1);
      end
    end
    $display("[TB] test_priority done");
  endtask

  task automatic test_wrap();
    int exp16;
    int exp19;
`ifdef SLT_PRESCALE_SATURATE_EN
    exp16 = 15; exp19 = 15;
`else
    exp16 = 0; exp19 = 3;
`endif
    do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 19; i++) begin
      do_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
      tests_run++;
      if (Count !== exp_count() || Tick !== exp_tick() || Ovf !== exp_ovf()) begin
        fails++;
        $display("FAIL wrap_cycle ev%0d: count=%h tick=%b ovf=%b required %h %b %b",
                 i + 1, Count, Tick, Ovf, exp_count(), exp_tick(), exp_ovf());
      end
      if (i == 15) begin
        tests_run++;
        if (ch_count(0) != exp16 || Ovf[0] !== 1'b1) begin
          fails++;
          $display("FAIL wrap16: count0=%0d ovf0=%b required %0d 1", ch_count(0), Ovf[0], exp16);
        end
      end
    end
    tests_run++;
    if (ch_count(0) != exp19 || Ovf[0] !== 1'b1) begin
      fails++;
      $display("FAIL wrap19: count0=%0d ovf0=%b required %0d 1", ch_count(0), Ovf[0], exp19);
    end
    do_cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    tests_run++;
    if (Ovf[0] !== 1'b0 || ch_count(0) != 0) begin
      fails++;
      $display("FAIL wrap_clr: ovf0=%b count0=%0d required 0 0", Ovf[0], ch_count(0));
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_invalid_select();
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b1, 3, 1'b1, 1'b1, 7);
      tests_run++;
      if (Count !== exp_count() || Tick !== '0 || Ovf !== exp_ovf()) begin
        fails++;
        $display("FAIL invalid_sel c%0d: count=%h tick=%b ovf=%b required %h 000 %b",
                 i, Count, Tick, Ovf, exp_count(), exp_ovf());
      end
    end
    do_cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
      tests_run++;
      if (Tick[1] !== (i == 3)) begin
        fails++;
        $display("FAIL reset_midpre ev%0d: tick1=%b required %b", i + 1, Tick[1], i == 3);
      end
    end
    $display("[TB] test_invalid_select done");
  endtask

  task automatic test_random();
    logic rst_n;
    logic en;
    logic clr;
    logic dwe;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en    = ($urandom_range(0, 9) < 7);
      clr   = ($urandom_range(0, 19) == 0);
      dwe   = ($urandom_range(0, 9) == 0);
      do_cycle(rst_n, en, int'($urandom_range(0, 3)), clr, dwe, int'($urandom_range(0, 5)));
      tests_run++;
      if (Count !== exp_count() || Tick !== exp_tick() || Ovf !== exp_ovf()) begin
        fails++;
        $display("FAIL random c%0d: count=%h tick=%b ovf=%b required %h %b %b",
                 i, Count, Tick, Ovf, exp_count(), exp_tick(), exp_ovf());
      end
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_count[i] = 0; m_pre[i] = 0; m_ovf[i] = 0; m_tick[i] = 0;
      m_div[i] = (i == 0) ? 1 : PRE_DEFAULT;
    end
    @(negedge Clk);
    test_reset();
    test_channel0();
    test_divisor();
    test_priority();
    test_wrap();
    test_invalid_select();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
